dffsr_test_sequencer: RTL and testbench



---
 rtl/dffsr_test_sequencer.sv | 166 ++++++++++++++++
 tb/tb_dffsr_test_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dffsr_test_sequencer.sv
// dffsr_test_sequencer
//   Self-test controller for a D flip-flop with async set/reset. Walks an
//   8-bit LFSR vector stream into the cell (slow clock, data, set, reset),
//   samples q/notq once per vector and compares against a reference model.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   start             single-cycle run request (honoured only when idle)
//   dut_clk/data/set/reset  stimulus to the cell under test
//   dut_q, dut_notq   cell outputs, sampled only in CHECK
//   busy              run in progress (CLEAR through the last CHECK)
//   done              run complete, sticky until next start or reset
//   pass              done and no mismatches
//   err_count         mismatch count, saturates at 255
//   vec_index         index of the vector currently applied
//   first_fail        (vec_index + 1) of the first mismatch, 0 if none
//
// Build option
//   DFFSR_SEQ_FIRST_FAIL_EN  builds the first_fail capture register;
//                            without it first_fail is tied to 0.
module dffsr_test_sequencer #(
  parameter int         NUM_VECTORS   = 64,
  parameter logic [7:0] LFSR_SEED     = 8'hA5,
  parameter int         SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       dut_clk,
  output logic       dut_data,
  output logic       dut_set,
  output logic       dut_reset,
  input  logic       dut_q,
  input  logic       dut_notq,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [9:0] vec_index,
  output logic [9:0] first_fail
);

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [7:0] SEED        = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [9:0] LAST        = 10'(NUM_VECTORS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_DRIVE, S_RISE, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  state_t     state, next_state;
  logic [3:0] cnt;
  logic [7:0] lfsr;
  logic       exp_q;

  // Vector decode; reset has priority so set and reset are never both high.
  logic v_reset, v_set, v_data, mismatch;
  assign v_reset  = lfsr[3] & lfsr[4];
  assign v_set    = lfsr[1] & lfsr[2] & ~v_reset;
  assign v_data   = lfsr[0];
  assign mismatch = (dut_q != exp_q) || (dut_notq != ~exp_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_CLEAR;
      S_CLEAR:  if (cnt == 4'd1) next_state = S_DRIVE;
      S_DRIVE:  next_state = S_RISE;
      S_RISE:   next_state = S_SETTLE;
      S_SETTLE: if (cnt == SETTLE_LAST) next_state = S_CHECK;
      S_CHECK:  next_state = (vec_index == LAST) ? S_DONE : S_DRIVE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Outputs to the cell; the vector is held from DRIVE through CHECK since
  // the LFSR only advances on the CHECK edge.
  always_comb begin
    busy      = 1'b0;
    dut_clk   = 1'b0;
    dut_data  = 1'b0;
    dut_set   = 1'b0;
    dut_reset = 1'b0;
    case (state)
      S_CLEAR: begin
        busy      = 1'b1;
        dut_reset = 1'b1;
      end
      S_DRIVE, S_RISE, S_SETTLE, S_CHECK: begin
        busy      = 1'b1;
        dut_clk   = (state == S_RISE) || (state == S_SETTLE);
        dut_data  = v_data;
        dut_set   = v_set;
        dut_reset = v_reset;
      end
      default: ;
    endcase
  end

  assign pass = done && (err_count == 8'd0);

  // Dwell counter for CLEAR and SETTLE; zeroed on every state change.
  always_ff @(posedge clk) begin
    if (reset)                    cnt <= 4'd0;
    else if (next_state != state) cnt <= 4'd0;
    else if (state == S_CLEAR || state == S_SETTLE) cnt <= cnt + 4'd1;
  end

  // Datapath: LFSR, reference model, counters, sticky done.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr      <= SEED;
      exp_q     <= 1'b0;
      err_count <= 8'd0;
      vec_index <= 10'd0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          lfsr      <= SEED;
          err_count <= 8'd0;
          vec_index <= 10'd0;
          done      <= 1'b0;
        end
        S_CLEAR: exp_q <= 1'b0;
        // Async controls take effect while dut_clk is still low.
        S_DRIVE: begin
          if (v_reset)    exp_q <= 1'b0;
          else if (v_set) exp_q <= 1'b1;
        end
        S_RISE: if (!v_reset && !v_set) exp_q <= v_data;
        S_CHECK: begin
          if (mismatch && err_count != 8'hFF) err_count <= err_count + 8'd1;
          // Fibonacci taps 8,6,5,4
          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
          if (vec_index == LAST) done <= 1'b1;
          else                   vec_index <= vec_index + 10'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef DFFSR_SEQ_FIRST_FAIL_EN
  logic [9:0] ff_q;
  always_ff @(posedge clk) begin
    if (reset)                               ff_q <= 10'd0;
    else if (state == S_IDLE && start)       ff_q <= 10'd0;
    else if (state == S_CHECK && mismatch && ff_q == 10'd0)
      ff_q <= vec_index + 10'd1;
  end
  assign first_fail = ff_q;
`else
  assign first_fail = 10'd0;
`endif

endmodule

// File: tb/tb_dffsr_test_sequencer.sv
// Bench for dffsr_test_sequencer: three instances (defaults, 300 vectors,
// SETTLE_CYCLES=3) each driving a behavioural cell, table rows for the
// default instance plus hand-written reset/saturation/settle sequences.
module tb_dffsr_test_sequencer;

`ifdef DFFSR_SEQ_FIRST_FAIL_EN
  localparam int FF_EXP = 6;
`else
  localparam int FF_EXP = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] start_v;
  int         checks = 0;
  int         errors = 0;

  // instance 0: defaults
  logic d_clk0, d_data0, d_set0, d_rst0, q0, nq0, busy0, done0, pass0;
  logic [7:0] err0;
  logic [9:0] vi0, ff0;
  // instance 1: 300 vectors, notq tied to q
  logic d_clk1, d_data1, d_set1, d_rst1, q1, nq1, busy1, done1, pass1;
  logic [7:0] err1;
  logic [9:0] vi1, ff1;
  // instance 2: SETTLE_CYCLES = 3
  logic d_clk2, d_data2, d_set2, d_rst2, q2, nq2, busy2, done2, pass2;
  logic [7:0] err2;
  logic [9:0] vi2, ff2;

  dffsr_test_sequencer u0 (
    .clk(clk), .reset(reset), .start(start_v[0]),
    .dut_clk(d_clk0), .dut_data(d_data0), .dut_set(d_set0), .dut_reset(d_rst0),
    .dut_q(q0), .dut_notq(nq0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .vec_index(vi0), .first_fail(ff0));

  dffsr_test_sequencer #(.NUM_VECTORS(300)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]),
    .dut_clk(d_clk1), .dut_data(d_data1), .dut_set(d_set1), .dut_reset(d_rst1),
    .dut_q(q1), .dut_notq(nq1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .vec_index(vi1), .first_fail(ff1));

  dffsr_test_sequencer #(.SETTLE_CYCLES(3)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]),
    .dut_clk(d_clk2), .dut_data(d_data2), .dut_set(d_set2), .dut_reset(d_rst2),
    .dut_q(q2), .dut_notq(nq2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .vec_index(vi2), .first_fail(ff2));

  // Ideal cells: async reset over set, rising-edge D.
  logic cell0, cell2;
  always @(posedge d_clk0 or posedge d_rst0 or posedge d_set0)
    if (d_rst0) cell0 <= 1'b0; else if (d_set0) cell0 <= 1'b1; else cell0 <= d_data0;
  always @(posedge d_clk2 or posedge d_rst2 or posedge d_set2)
    if (d_rst2) cell2 <= 1'b0; else if (d_set2) cell2 <= 1'b1; else cell2 <= d_data2;

  // mode0: 0 ideal, 1 q stuck 0 / notq stuck 1, 2 q inverted on vector 5
  int mode0;
  always_comb begin
    q0  = cell0 ^ ((mode0 == 2) && (vi0 == 10'd5));
    nq0 = ~cell0;
    if (mode0 == 1) begin
      q0  = 1'b0;
      nq0 = 1'b1;
    end
  end
  assign q1  = 1'b0;
  assign nq1 = q1;
  assign q2  = cell2;
  assign nq2 = ~cell2;

  logic [2:0] done_v, busy_v;
  assign done_v = {done2, done1, done0};
  assign busy_v = {busy2, busy1, busy0};

  int sr_viol = 0;
  always @(negedge clk)
    if ((d_set0 & d_rst0) | (d_set1 & d_rst1) | (d_set2 & d_rst2)) sr_viol++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Number of vectors whose expected Q is 1 (each vector fully determines it).
  function automatic int ones_cnt(input logic [7:0] seed, input int n);
    logic [7:0] l;
    logic r, s, e;
    int c;
    l = seed;
    c = 0;
    for (int i = 0; i < n; i++) begin
      r = l[3] & l[4];
      s = l[1] & l[2] & ~r;
      e = r ? 1'b0 : (s ? 1'b1 : l[0]);
      if (e) c++;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    return c;
  endfunction

  int clk_bad = 0;
  int clk_runs = 0;

  // Pulse start, then count edges until done (lat = edges after the start edge).
  task automatic run_seq(input int sel, input int maxc, output int lat);
    int hi;
    @(negedge clk); start_v[sel] = 1'b1;
    @(negedge clk); start_v[sel] = 1'b0;
    chk("busy_after_start", 32'(busy_v[sel]), 32'd1);
    lat = 0;
    hi  = 0;
    while (!done_v[sel] && lat < maxc) begin
      if (sel == 2) start_v[2] = (lat % 25 == 5);
      @(negedge clk);
      lat++;
      if (sel == 2) begin
        if (d_clk2) hi++;
        else begin
          if (hi != 0) begin
            clk_runs++;
            if (hi != 4) clk_bad++;
          end
          hi = 0;
        end
      end
    end
    start_v[sel] = 1'b0;
  endtask

  typedef struct {
    int   mode;
    int   exp_lat;
    int   exp_err;
    logic exp_pass;
    int   exp_ff;
  } vec_t;

  vec_t tbl[3];
  int   lat;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 258, 0, 1'b1, 0};
    tbl[1] = '{1, 258, ones_cnt(8'hA5, 64), 1'b0, FF_EXP == 0 ? 0 : -1};
    tbl[2] = '{2, 258, 1, 1'b0, FF_EXP};

    reset   = 1'b1;
    start_v = 3'b000;
    mode0   = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'({busy0, done0, pass0, err0, vi0, ff0,
                            d_clk0, d_data0, d_set0, d_rst0}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      mode0 = tbl[i].mode;
      run_seq(0, 400, lat);
      chk($sformatf("row%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("row%0d_err_count", i), 32'(err0), 32'(tbl[i].exp_err));
      chk($sformatf("row%0d_pass", i), 32'(pass0), 32'(tbl[i].exp_pass));
      chk($sformatf("row%0d_vec_index", i), 32'(vi0), 32'd63);
      if (tbl[i].exp_ff >= 0)
        chk($sformatf("row%0d_first_fail", i), 32'(ff0), 32'(tbl[i].exp_ff));
      @(negedge clk);
      chk($sformatf("row%0d_done_sticky", i), 32'({done0, busy0}), 32'b10);
    end

    // Reset in the middle of vector 10 (stuck cell so err_count is nonzero).
    mode0 = 1;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    begin
      int w;
      w = 0;
      while (vi0 != 10'd10 && w < 200) begin
        @(negedge clk);
        w++;
      end
    end
    chk("reach_vec10", 32'(vi0), 32'd10);
    reset = 1'b1;
    @(negedge clk);
    chk("midrun_reset_clears", 32'({busy0, done0, pass0, err0, vi0, ff0,
                                    d_clk0, d_data0, d_set0, d_rst0}), 32'd0);
    reset = 1'b0;
    mode0 = 0;
    run_seq(0, 400, lat);
    chk("rerun_latency", 32'(lat), 32'd258);
    chk("rerun_pass", 32'(pass0), 32'd1);

    // Saturation: every vector mismatches, 300 of them.
    run_seq(1, 1400, lat);
    chk("sat_latency", 32'(lat), 32'd1202);
    chk("sat_err_count", 32'(err1), 32'd255);
    chk("sat_pass", 32'(pass1), 32'd0);

    // SETTLE_CYCLES = 3 with repeated starts while busy.
    run_seq(2, 500, lat);
    chk("settle3_latency", 32'(lat), 32'd386);
    chk("settle3_pass", 32'(pass2), 32'd1);
    chk("settle3_clk_high_runs", 32'(clk_runs), 32'd64);
    chk("settle3_clk_high_len_bad", 32'(clk_bad), 32'd0);

    chk("set_reset_overlap", 32'(sr_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
